// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 16x oversampling with its own baud
// prescaler, 3-sample majority vote per bit, variable data length, optional
// even/odd parity and one or two stop bits. Rx is synchronised by two flops.
module uart_rx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 10,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_en,
  input  logic              Rx,
  input  logic [DIV_W-1:0]  Load_Value,
  input  logic [LEN_W-1:0]  data_len,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [3:0]          s_q, s_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                samp7_q, samp7_d;
  logic                samp8_q, samp8_d;
  logic                samp9_q, samp9_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DIV_W-1:0]    load_q, load_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                par_en_q, par_en_d;
  logic                par_odd_q, par_odd_d;
  logic                two_stop_q, two_stop_d;
  logic                par_res_q, par_res_d;
  logic                stop1_q, stop1_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                frame_err_q, frame_err_d;
  logic                parity_err_q, parity_err_d;

  logic                tick;
  logic                maj_mid;
  logic                maj_end;
  logic [LEN_W-1:0]    len_eff;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign tick    = (state_q != S_IDLE) && (presc_q == load_q);
  // At s=9 the third sample is the live synchronised line value.
  assign maj_mid = maj3(samp7_q, samp8_q, rx_s_q);
  // At s=15 all three samples of the bit are already registered.
  assign maj_end = maj3(samp7_q, samp8_q, samp9_q);
  // A zero or out-of-range length selects the full word width.
  assign len_eff = ((data_len == '0) || (data_len > LEN_W'(DATA_W)))
                   ? LEN_W'(DATA_W) : data_len;

  assign data       = data_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state logic: prescaler, oversample counter, sampling and frame FSM.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    s_d          = s_q;
    bit_cnt_d    = bit_cnt_q;
    samp7_d      = samp7_q;
    samp8_d      = samp8_q;
    samp9_d      = samp9_q;
    shreg_d      = shreg_q;
    load_d       = load_q;
    len_d        = len_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    two_stop_d   = two_stop_q;
    par_res_d    = par_res_q;
    stop1_d      = stop1_q;
    data_d       = data_q;
    done_d       = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    if (state_q != S_IDLE) begin
      presc_d = tick ? '0 : presc_q + DIV_W'(1);
    end

    if (tick) begin
      s_d = s_q + 4'd1;
      if (s_q == 4'd7) samp7_d = rx_s_q;
      if (s_q == 4'd8) samp8_d = rx_s_q;
      if (s_q == 4'd9) samp9_d = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_en && !rx_s_q) begin
          state_d    = S_START;
          presc_d    = '0;
          s_d        = '0;
          bit_cnt_d  = '0;
          shreg_d    = '0;
          par_res_d  = 1'b0;
          stop1_d    = 1'b1;
          load_d     = Load_Value;
          len_d      = len_eff;
          par_en_d   = parity_en;
          par_odd_d  = parity_odd;
          two_stop_d = two_stop;
        end
      end

      S_START: begin
        if (tick && s_q == 4'd15) begin
          if (maj_end) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
      end

      S_DATA: begin
        if (tick && s_q == 4'd15) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == LEN_W'(i)) shreg_d[i] = maj_end;
          end
          if (bit_cnt_q == len_q - LEN_W'(1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + LEN_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (tick && s_q == 4'd15) begin
          // Unused high bits of shreg are zero, so a full-width XOR is exact.
          par_res_d = ((^shreg_q) ^ maj_end) != par_odd_q;
          state_d   = S_STOP1;
        end
      end

      S_STOP1: begin
        if (tick && s_q == 4'd9) begin
          stop1_d = maj_mid;
          if (two_stop_q) begin
            state_d = S_STOP2;
          end else begin
            state_d      = S_IDLE;
            done_d       = 1'b1;
            data_d       = shreg_q;
            frame_err_d  = !maj_mid;
            parity_err_d = par_en_q & par_res_q;
          end
        end
      end

      S_STOP2: begin
        if (tick && s_q == 4'd9) begin
          state_d      = S_IDLE;
          done_d       = 1'b1;
          data_d       = shreg_q;
          frame_err_d  = !(stop1_q & maj_mid);
          parity_err_d = par_en_q & par_res_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset wins over everything, including a frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      s_q          <= '0;
      bit_cnt_q    <= '0;
      samp7_q      <= 1'b1;
      samp8_q      <= 1'b1;
      samp9_q      <= 1'b1;
      shreg_q      <= '0;
      load_q       <= '0;
      len_q        <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      par_res_q    <= 1'b0;
      stop1_q      <= 1'b1;
      data_q       <= '0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      s_q          <= s_d;
      bit_cnt_q    <= bit_cnt_d;
      samp7_q      <= samp7_d;
      samp8_q      <= samp8_d;
      samp9_q      <= samp9_d;
      shreg_q      <= shreg_d;
      load_q       <= load_d;
      len_q        <= len_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      two_stop_q   <= two_stop_d;
      par_res_q    <= par_res_d;
      stop1_q      <= stop1_d;
      data_q       <= data_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are driven bit by bit on Rx and the
// captured done/data/flags are compared against hand-computed values.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_en;
  logic        rx;
  logic [9:0]  load_value;
  logic [3:0]  data_len;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic [7:0]  data;
  logic        done;
  logic        busy;
  logic        frame_err;
  logic        parity_err;

  int checks = 0;
  int errors = 0;
  int lv     = 3;

  int          done_cnt = 0;
  logic [7:0]  cap_data = '0;
  logic        cap_fe   = 1'b0;
  logic        cap_pe   = 1'b0;
  logic        cap_busy = 1'b0;

  int d0;

  uart_rx_cfg dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .Rx         (rx),
    .Load_Value (load_value),
    .data_len   (data_len),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .data       (data),
    .done       (done),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Record every done pulse together with the outputs seen in that cycle.
  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      cap_data <= data;
      cap_fe   <= frame_err;
      cap_pe   <= parity_err;
      cap_busy <= busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame. last_cyc>0 truncates the final stop bit; glitch raises
  // the line for 4 cycles around the s=8 sample of data bit 2.
  task automatic send_frame(input logic [15:0] d, input int nbits, input bit pen,
                            input bit pbit, input bit two, input bit s2val,
                            input int last_cyc, input bit glitch);
    logic bits[$];
    int   bitc;
    int   ncyc;
    bitc = 16 * (lv + 1);
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(1'b1);
    if (two) bits.push_back(s2val);
    for (int b = 0; b < bits.size(); b++) begin
      ncyc = (b == bits.size() - 1 && last_cyc > 0) ? last_cyc : bitc;
      for (int c = 0; c < ncyc; c++) begin
        rx = bits[b] ^ (glitch && b == 3 && c >= 34 && c < 38);
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    rx_en      = 1'b0;
    rx         = 1'b1;
    load_value = 10'd3;
    data_len   = 4'd0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    idle(3);
    check("rst_data", 32'(data), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    rst   = 1'b0;
    rx_en = 1'b1;
    idle(10);

    // 8N1 0xD3, data_len=0 selects the full 8 bits.
    d0 = done_cnt;
    send_frame(16'hD3, 8, 0, 0, 0, 1, 0, 0);
    idle(20);
    check("d3_done", 32'(done_cnt), 32'(d0 + 1));
    check("d3_data", 32'(cap_data), 32'hD3);
    check("d3_ferr", 32'(cap_fe), 32'h0);
    check("d3_perr", 32'(cap_pe), 32'h0);
    check("d3_busy", 32'(cap_busy), 32'h0);

    // 7E1: 0x55 has four ones, so parity bit 1 is wrong, 0 is right.
    data_len  = 4'd7;
    parity_en = 1'b1;
    send_frame(16'h55, 7, 1, 1, 0, 1, 0, 0);
    idle(128);
    check("par1_data", 32'(cap_data), 32'h55);
    check("par1_perr", 32'(cap_pe), 32'h1);
    d0 = done_cnt;
    send_frame(16'h55, 7, 1, 0, 0, 1, 0, 0);
    idle(128);
    check("par0_done", 32'(done_cnt), 32'(d0 + 1));
    check("par0_perr", 32'(cap_pe), 32'h0);

    // 8N2 with a bad second stop bit, then a clean frame.
    data_len  = 4'd8;
    parity_en = 1'b0;
    two_stop  = 1'b1;
    d0 = done_cnt;
    send_frame(16'hA5, 8, 0, 0, 1, 0, 0, 0);
    idle(150);
    check("a5_done", 32'(done_cnt), 32'(d0 + 1));
    check("a5_data", 32'(cap_data), 32'hA5);
    check("a5_ferr", 32'(cap_fe), 32'h1);
    send_frame(16'h3C, 8, 0, 0, 1, 1, 0, 0);
    idle(128);
    check("3c_data", 32'(cap_data), 32'h3C);
    check("3c_ferr", 32'(cap_fe), 32'h0);

    // False start: line low for 4 ticks only.
    two_stop = 1'b0;
    d0 = done_cnt;
    rx = 1'b0;
    idle(8);
    check("fs_busy_hi", 32'(busy), 32'h1);
    idle(8);
    rx = 1'b1;
    idle(40);
    check("fs_busy_mid", 32'(busy), 32'h1);
    idle(30);
    check("fs_busy_lo", 32'(busy), 32'h0);
    check("fs_nodone", 32'(done_cnt), 32'(d0));
    check("fs_data", 32'(data), 32'h3C);

    // Glitch on data bit 2 of 0x00, then 0xFF right after the stop mid-point.
    d0 = done_cnt;
    send_frame(16'h00, 8, 0, 0, 0, 1, 44, 1);
    check("gl_done", 32'(done_cnt), 32'(d0 + 1));
    check("gl_data", 32'(cap_data), 32'h00);
    send_frame(16'hFF, 8, 0, 0, 0, 1, 0, 0);
    idle(20);
    check("b2b_done", 32'(done_cnt), 32'(d0 + 2));
    check("b2b_data", 32'(cap_data), 32'hFF);

    // Reset in the middle of a frame, after data bit 3.
    d0 = done_cnt;
    rx = 1'b0;
    idle(64);
    rx = 1'b1;
    idle(256);
    check("mr_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_data", 32'(data), 32'h0);
    idle(700);
    check("mr_nodone", 32'(done_cnt), 32'(d0));

    // 0x81 at the fastest prescaler setting with an oversized data_len.
    lv         = 0;
    load_value = 10'd0;
    data_len   = 4'd12;
    send_frame(16'h81, 8, 0, 0, 0, 1, 0, 0);
    idle(40);
    check("81_done", 32'(done_cnt), 32'(d0 + 1));
    check("81_data", 32'(cap_data), 32'h81);
    check("81_ferr", 32'(cap_fe), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver that generalises the fixed 8N1 UART_Rx.
- Integrates its own baud prescaler and 16x oversample counter.
- Configurable data length, optional even/odd parity, one or two stop bits.
- 3-sample majority voting per bit; a 2-FF synchroniser on Rx.
- Sits behind the APB wrapper; the register block drives configuration and consumes data, done and the error flags.

Parameters:
DATA_W, 8, maximum data bits per frame (5..16).
DIV_W, 10, width of Load_Value prescaler reload.
LEN_W, 4, width of data_len field; must satisfy 2**LEN_W > DATA_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_en  in  1  receiver enable; sampled only in IDLE
Rx  in  1  serial line, asynchronous, idle high
Load_Value  in  DIV_W  prescaler reload; oversample tick period = Load_Value+1 clocks
data_len  in  LEN_W  data bits per frame; 0 or >DATA_W means DATA_W
parity_en  in  1  1 = parity bit present
parity_odd  in  1  1 = odd parity, 0 = even
two_stop  in  1  1 = two stop bits
data  out  DATA_W  received word, LSB-aligned, unused MSBs zero
done  out  1  one-cycle pulse, frame complete
busy  out  1  frame in progress
frame_err  out  1  a stop bit sampled 0; valid with done
parity_err  out  1  parity mismatch; valid with done

Behaviour:
- Reset: all outputs 0; state IDLE; prescaler, oversample counter and bit counter 0; both synchroniser flops 1. rst has priority over all other activity, including mid-frame: IDLE on the next edge, no done.
- Rx passes through 2 flops (rx_s). All decisions use rx_s, giving 2 cycles of latency.
- Prescaler: runs only outside IDLE.
  - Cleared to 0 on start detect.
  - Emits a one-cycle tick when the count equals Load_Value, then wraps to 0.
  - Load_Value=0 gives a tick every cycle.
- Oversample counter s (4 bit): increments on each tick and wraps 15 -> 0.
- Per bit, samples are taken on the ticks where s is 7, 8 and 9. The bit value is the majority of the three (2 of 3).
- Configuration (Load_Value, data_len, parity_en, parity_odd, two_stop) is latched on start detect. Changes mid-frame have no effect.
- States:
  - IDLE: busy=0. If rx_en=1 and rx_s=0, go to START (start detect), with s=0. Deasserting rx_en mid-frame does not abort the frame.
  - START: at the tick with s=15, if majority=1 (false start) go to IDLE with no done and no flag change. Otherwise go to DATA with bit index 0.
  - DATA: at the tick with s=15, store the majority into shift position (LSB first). After data_len bits, go to PARITY if parity_en, else STOP1.
  - PARITY: at the tick with s=15, compute parity_err_next = (XOR of data bits XOR parity bit) != parity_odd. Go to STOP1.
  - STOP1: at the tick with s=9, record stop1 = majority.
    - If two_stop, go to STOP2 (s continues to 15, then wraps).
    - Otherwise complete the frame.
  - STOP2: at the tick with s=9, record stop2 and complete the frame.
- Frame complete (same cycle): done=1 for exactly one cycle.
  - data updated with bits above data_len zeroed.
  - frame_err = any stop sample 0.
  - parity_err = parity result, or 0 if parity disabled.
  - Return to IDLE. Completing at mid-stop lets a back-to-back start edge be caught.
- data, frame_err and parity_err hold until the next done or rst.
- busy=1 in every state except IDLE. busy falls in the cycle done is high.
- Error frames still assert done and update data.

Test Plan:
- 8N1, Load_Value=650 (bit time 10416 clocks), send 0xD3 LSB first -> exactly one done pulse; data=0xD3, frame_err=0, parity_err=0, busy=0 in done cycle.
- data_len=7, parity_en=1, parity_odd=0, send 0x55 with parity bit 1 -> data=0x55, parity_err=1. Resend with parity bit 0 -> parity_err=0.
- 8N2, send 0xA5 with second stop bit driven 0 -> done, data=0xA5, frame_err=1. Next clean frame 0x3C -> frame_err=0.
- In IDLE, Rx low for 4 ticks then high -> busy rises then falls at s=15 of START; no done; data unchanged.
- Within data bit 2 of frame 0x00, Rx pulsed high only for the tick with s=8 -> data=0x00 (majority rejects glitch). Back-to-back 0xFF frame starting right after the stop mid-point -> second done with data=0xFF.
- rst=1 for 1 cycle after bit 3 of a frame -> next cycle busy=0, data=0, done never fires for that frame. Following 0x81 frame is received correctly.
